// File: rtl/nn_pkg.sv
// Shared types, Q-format constants and arithmetic helpers for the streaming classifier head.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_BIAS = 3'd2,
    S_ACT  = 3'd3,
    S_OUT  = 3'd4
  } nn_state_e;

  localparam int FRAC_BITS_DEF = 10;
  localparam int ONE           = 1 << FRAC_BITS_DEF;
  localparam int HALF          = ONE / 2;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // 0.25*z + 0.5 clamped to [0, 1.0] in a Q-format with fb fractional bits.
  function automatic logic signed [63:0] hard_sigmoid(input logic signed [63:0] z, input int fb);
    logic signed [63:0] one;
    logic signed [63:0] t;
    one = 64'sd1 <<< fb;
    t   = (z >>> 2) + (one >>> 1);
    if (t < 64'sd0) return 64'sd0;
    if (t > one) return one;
    return t;
  endfunction

endpackage

// File: rtl/nn_lane_mac.sv
// One classifier lane: multiply-accumulate, bias add with saturation, hard-sigmoid activation.
module nn_lane_mac
  import nn_pkg::*;
#(
  parameter int DW = 16,
  parameter int FB = 10,
  parameter int AW = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic                 bias_en,
  input  logic                 act_en,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] z,
  output logic signed [DW-1:0] a,
  output logic                 sat_hit
);

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   z_q, z_d;
  logic signed [DW-1:0]   a_q, a_d;
  logic signed [2*DW-1:0] prod;
  logic signed [63:0]     pre_wide;
  logic signed [63:0]     z_wide;

  assign prod     = (2*DW)'(x) * (2*DW)'(w);
  // Arithmetic shift floors toward minus infinity; no rounding is applied.
  assign pre_wide = 64'(acc_q >>> FB) + 64'(bias);
  assign z_wide   = sat(pre_wide, DW);
  assign sat_hit  = bias_en && (z_wide != pre_wide);

  always_comb begin
    acc_d = acc_q;
    z_d   = z_q;
    a_d   = a_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + AW'(prod);
    end
    if (bias_en) z_d = DW'(z_wide);
    if (act_en)  a_d = DW'(hard_sigmoid(64'(z_q), FB));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      z_q   <= '0;
      a_q   <= '0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      a_q   <= a_d;
    end
  end

  assign z = z_q;
  assign a = a_q;

endmodule

// File: rtl/nn_classifier_stream.sv
// Streaming classifier head: frame FSM, beat counter and N_CH parallel lanes with per-lane decisions.
module nn_classifier_stream
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int N_CH       = 3,
  parameter int N_FEAT     = 9,
  parameter int ACC_WIDTH  = 40,
  parameter int THRESH     = HALF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [DATA_WIDTH-1:0]    bias,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_CH*DATA_WIDTH-1:0]      x_flat,
  input  logic signed [DATA_WIDTH-1:0]    w,
  output logic [N_CH*DATA_WIDTH-1:0]      z_flat,
  output logic [N_CH*DATA_WIDTH-1:0]      a_flat,
  output logic [N_CH-1:0]                 unhealthy,
  output logic                            sat_flag,
  output logic                            busy,
  output logic                            done
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(N_FEAT + 1);
  localparam logic signed [DW-1:0] THRESH_W = DW'(THRESH);

  // Beat handshake: a beat transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on state, and x_flat/w/in_valid must be held while in_ready is low.

  nn_state_e              state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic signed [DW-1:0]   bias_q, bias_d;
  logic                   sat_flag_q, sat_flag_d;
  logic                   done_q, done_d;
  logic [N_CH*DW-1:0]     z_out_q, z_out_d;
  logic [N_CH*DW-1:0]     a_out_q, a_out_d;
  logic [N_CH-1:0]        unh_q, unh_d;

  logic                   clr, acc_en, bias_en, act_en;
  logic [N_CH*DW-1:0]     z_lane, a_lane;
  logic [N_CH-1:0]        sat_hit, unh_calc;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    nn_lane_mac #(
      .DW(DW),
      .FB(FRAC_BITS),
      .AW(ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .acc_en  (acc_en),
      .bias_en (bias_en),
      .act_en  (act_en),
      .x       (x_flat[c*DW +: DW]),
      .w       (w),
      .bias    (bias_q),
      .z       (z_lane[c*DW +: DW]),
      .a       (a_lane[c*DW +: DW]),
      .sat_hit (sat_hit[c])
    );
    assign unh_calc[c] = $signed(a_lane[c*DW +: DW]) >= THRESH_W;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    bias_d     = bias_q;
    sat_flag_d = sat_flag_q;
    done_d     = 1'b0;
    z_out_d    = z_out_q;
    a_out_d    = a_out_q;
    unh_d      = unh_q;
    clr        = 1'b0;
    acc_en     = 1'b0;
    bias_en    = 1'b0;
    act_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d     = bias;
          beat_d     = '0;
          sat_flag_d = 1'b0;
          clr        = 1'b1;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_en = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == CNT_W'(N_FEAT - 1)) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        bias_en = 1'b1;
        if (|sat_hit) sat_flag_d = 1'b1;
        state_d = S_ACT;
      end
      S_ACT: begin
        act_en  = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        z_out_d = z_lane;
        a_out_d = a_lane;
        unh_d   = unh_calc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      bias_q     <= '0;
      sat_flag_q <= 1'b0;
      done_q     <= 1'b0;
      z_out_q    <= '0;
      a_out_q    <= '0;
      unh_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      bias_q     <= bias_d;
      sat_flag_q <= sat_flag_d;
      done_q     <= done_d;
      z_out_q    <= z_out_d;
      a_out_q    <= a_out_d;
      unh_q      <= unh_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  // The done cycle already sits in IDLE, so busy is extended through it.
  assign busy      = (state_q != S_IDLE) || done_q;
  assign done      = done_q;
  assign z_flat    = z_out_q;
  assign a_flat    = a_out_q;
  assign unhealthy = unh_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_nn_classifier_stream.sv
// Directed bench for nn_classifier_stream: hand-computed frames, stalls, ignored starts and mid-frame reset.
module tb_nn_classifier_stream;

  localparam int DW = 16;
  localparam int NC = 3;
  localparam int NF = 9;
  localparam int EW = 2*NC*DW + NC + 1;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic signed [DW-1:0] bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [NC*DW-1:0]     x_flat;
  logic signed [DW-1:0] w;
  logic [NC*DW-1:0]     z_flat;
  logic [NC*DW-1:0]     a_flat;
  logic [NC-1:0]        unhealthy;
  logic                 sat_flag;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  nn_classifier_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .w         (w),
    .z_flat    (z_flat),
    .a_flat    (a_flat),
    .unhealthy (unhealthy),
    .sat_flag  (sat_flag),
    .busy      (busy),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input int z0, input int z1, input int z2,
                                             input int a0, input int a1, input int a2,
                                             input logic [NC-1:0] unh, input logic sat);
    return {DW'(z2), DW'(z1), DW'(z0), DW'(a2), DW'(a1), DW'(a0), unh, sat};
  endfunction

  // Driver: one frame with constant lane data; scoreboard pop on done.
  task automatic run_frame(input int b, input int x0, input int x1, input int x2, input int wv,
                           input bit stall, input bit poke);
    logic [EW-1:0] e;
    int acc_n;
    int guard;
    int lat;
    bit got;
    start = 1'b1;
    bias  = DW'(b);
    @(posedge clk); #1;
    start = 1'b0;
    bias  = '0;
    check("ready_after_start", 64'(in_ready), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    check("sat_clr_at_start", 64'(sat_flag), 64'd0);
    x_flat = {DW'(x2), DW'(x1), DW'(x0)};
    w      = DW'(wv);
    acc_n  = 0;
    guard  = 0;
    while (acc_n < NF && guard < 200) begin
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start = 1'($urandom_range(0, 1));
      got = in_valid && in_ready;
      @(posedge clk); #1;
      if (got) acc_n++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("beats_accepted", 64'(acc_n), 64'(NF));
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", 64'(lat), 64'd3);
    e = exp_q.pop_front();
    check("z_flat", 64'(z_flat), 64'(e[EW-1 -: NC*DW]));
    check("a_flat", 64'(a_flat), 64'(e[NC+1 +: NC*DW]));
    check("unhealthy", 64'(unhealthy), 64'(e[1 +: NC]));
    check("sat_flag", 64'(sat_flag), 64'(e[0]));
    check("busy_at_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("done_pulse_width", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int dcount;
    rst      = 1'b1;
    start    = 1'b0;
    bias     = '0;
    in_valid = 1'b0;
    x_flat   = '0;
    w        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", 64'(z_flat), 64'd0);
    check("rst_a", 64'(a_flat), 64'd0);
    check("rst_unh", 64'(unhealthy), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero features, negative bias: activation clamps at 0.
    exp_q.push_back(pack_exp(-3165, -3165, -3165, 0, 0, 0, 3'b000, 1'b0));
    run_frame(-3165, 0, 0, 0, 777, 1'b0, 1'b0);

    // 1.0 * 1.0 over 9 beats: z = 9.0, a clamps at 1.0.
    exp_q.push_back(pack_exp(9216, 9216, 9216, 1024, 1024, 1024, 3'b111, 1'b0));
    run_frame(0, 1024, 1024, 1024, 1024, 1'b0, 1'b0);

    // Mixed lanes; lane 0 sits exactly on the threshold.
    exp_q.push_back(pack_exp(0, 1152, -1152, 512, 800, 224, 3'b011, 1'b0));
    run_frame(0, 0, 512, -512, 256, 1'b0, 1'b0);

    // Positive overflow saturates z and raises sat_flag.
    exp_q.push_back(pack_exp(32767, 32767, 32767, 1024, 1024, 1024, 3'b111, 1'b1));
    run_frame(0, 31744, 31744, 31744, 31744, 1'b0, 1'b0);

    // Following zero frame must clear sat_flag.
    exp_q.push_back(pack_exp(0, 0, 0, 512, 512, 512, 3'b111, 1'b0));
    run_frame(0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Mixed-lane frame again with random stalls and stray start pulses.
    exp_q.push_back(pack_exp(0, 1152, -1152, 512, 800, 224, 3'b011, 1'b0));
    run_frame(0, 0, 512, -512, 256, 1'b1, 1'b1);

    // Reset at beat 5 of a frame.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    x_flat   = {DW'(1024), DW'(1024), DW'(1024)};
    w        = DW'(1024);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_z", 64'(z_flat), 64'd0);
    check("midrst_a", 64'(a_flat), 64'd0);
    check("midrst_unh", 64'(unhealthy), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    dcount = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    rst = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("no_spurious_done", 64'(dcount), 64'd0);

    exp_q.push_back(pack_exp(9216, 9216, 9216, 1024, 1024, 1024, 3'b111, 1'b0));
    run_frame(0, 1024, 1024, 1024, 1024, 1'b0, 1'b0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_classifier_stream.md
# nn_classifier_stream

Parametrised streaming classifier head for the NIDS-VAE datapath. It accepts N_CH feature lanes in Q-format fixed point, one feature index per beat, all lanes sharing one weight per beat. Per lane it accumulates a dot product, adds a bias, applies a hard-sigmoid activation and thresholds the result into an `unhealthy` flag. It succeeds the fixed 3-lane forward/classification top, adding a valid/ready input handshake, configurable depth and lane count, saturation reporting, and per-lane decisions.

## Interface
- `DATA_WIDTH`, 16: word width of x, w, bias, z and a (signed).
- `FRAC_BITS`, 10: fractional bits (Q6.10 by default).
- `N_CH`, 3: number of parallel lanes.
- `N_FEAT`, 9: beats (features) per frame.
- `ACC_WIDTH`, 40: accumulator width; must be ≥ 2·DATA_WIDTH + clog2(N_FEAT).
- `THRESH`, 512 (0.5): activation threshold; `unhealthy[c] = (a_c >= THRESH)`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `bias`  in  DATA_WIDTH  signed bias; latched on an accepted `start`.
- `in_valid`  in  1  beat present on `x_flat`/`w`.
- `in_ready`  out  1  high only in ACC.
- `x_flat`  in  N_CH·DATA_WIDTH  lane c occupies bits [c·DW +: DW], signed.
- `w`  in  DATA_WIDTH  shared signed weight for the beat.
- `z_flat`  out  N_CH·DATA_WIDTH  saturated pre-activation per lane.
- `a_flat`  out  N_CH·DATA_WIDTH  activation per lane, range [0, 1.0].
- `unhealthy`  out  N_CH  per-lane decision.
- `sat_flag`  out  1  at least one lane's z saturated in the last frame.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse when the outputs are updated.

## Operation
- FSM states: IDLE → ACC → BIAS → ACT → OUT → IDLE.
- **IDLE:** when `start` is high, latch `bias`, clear all accumulators, beat counter and `sat_flag`, then go to ACC.
- **ACC:** on `in_valid && in_ready`, `acc_c += x_c * w`. The full 2·DW product is sign-extended to ACC_WIDTH. The counter increments. When the accepted beat is number N_FEAT−1, go to BIAS. A low `in_valid` stalls the frame with no state change.
- **BIAS:** `z_c = sat(acc_c >>> FRAC_BITS + sext(bias))`.
  - The shift is arithmetic (floor, no rounding).
  - `sat` clamps to [−2^(DW−1), 2^(DW−1)−1].
  - Any clamp sets `sat_flag`.
- **ACT:** hard sigmoid `a_c = clamp((z_c >>> 2) + 2^(FRAC_BITS−1), 0, 2^FRAC_BITS)`, i.e. 0.25·z + 0.5 clamped to [0, 1].
- **OUT:** register `unhealthy[c] = a_c >= THRESH`, pulse `done`, return to IDLE.
- `z_flat`, `a_flat`, `unhealthy` and `sat_flag` hold their values until the next frame's OUT. `sat_flag` is the exception: it clears at `start`.
- `start` outside IDLE is ignored and never restarts a frame.
- Accumulation does not wrap, given the ACC_WIDTH constraint; the only overflow handling is the saturation in BIAS.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No `done` is produced and the next `start` begins cleanly.
- `start` high in IDLE at edge k gives `in_ready` high from cycle k+1.
- Last beat accepted at edge n gives BIAS at n+1 and ACT at n+2. `done` is high and the new outputs are visible in the cycle after edge n+3.
- Minimum frame length is N_FEAT + 4 cycles including the IDLE `start` cycle. Back-to-back frames are possible by holding `start` high.
- `busy` is high from the cycle after `start` until `done` falls.

## Structure
- Package `nn_pkg` holds:
  - the state enum;
  - the Q-format constants ONE = 2^FRAC_BITS and HALF;
  - the `sat` and `hard_sigmoid` functions, parametrised through arguments.
- Sub-module `nn_lane_mac`: one lane's accumulator, bias add, saturation and activation, with local control strobes (`clr`, `acc_en`, `bias_en`, `act_en`). The top holds the FSM, the counter and a `generate` loop over N_CH.

## Test plan
- Stimulus: x = 0 on all lanes for 9 beats, any w, bias = −3.091 (−3165). Required: z = −3165, a = 0 (computed −280 clamps to 0), unhealthy = 0, sat_flag = 0.
- Stimulus: x = 1.0 (1024) on all lanes, w = 1.0 for 9 beats, bias = 0. Required: z = 9216, a = 1024, unhealthy = 3'b111.
- Stimulus: x = {0, 0.5, −0.5} (0, 512, −512), w = 0.25 (256) for 9 beats, bias = 0. Required:
  - z = {0, 1152, −1152};
  - a = {512, 800, 224};
  - unhealthy = {1, 1, 0}; lane 0 checks the ≥ boundary.
- Stimulus: x = w = 31.0 (31744) for 9 beats. Required: z = 32767 on all lanes, sat_flag = 1, a = 1024. The next frame with zero inputs must clear sat_flag.
- Stimulus: `in_valid` toggled randomly, plus `start` pulses during ACC. Required: `done` exactly 3 cycles after the 9th accepted beat, and results identical to the stall-free run.
- Stimulus: assert `rst` at beat 5, then run the case-2 frame. Required: all outputs 0 during reset, no spurious `done`, case-2 results reproduced.
